// File: rtl/dsp_adder_arbiter_pkg.sv
// Shared definitions for the adder arbiter: FSM encoding, default sizes and the
// requester-index width helper.
package dsp_adder_arbiter_pkg;

  localparam int unsigned DEFAULT_WIDTH   = 32;
  localparam int unsigned DEFAULT_NUM_REQ = 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  // A single requester still needs a one-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dsp_adder_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: scans from ptr+1 cyclically and grants the
// first active request, returning a one-hot grant and the winner's index.
module dsp_adder_arbiter_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDW     = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [IDW-1:0]     index_c,
  output logic               found_c
);

  int unsigned cand;

  always_comb begin
    grant_c = '0;
    index_c = '0;
    found_c = 1'b0;
    cand    = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(ptr) + k) % NUM_REQ;
      if (!found_c && req[IDW'(cand)]) begin
        found_c              = 1'b1;
        grant_c[IDW'(cand)]  = 1'b1;
        index_c              = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/dsp_adder_arbiter.sv
// Shares one external 32-bit adder among NUM_REQ requesters with round-robin
// arbitration, registered operands/result and valid/ready on both sides.
module dsp_adder_arbiter
  import dsp_adder_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned IDW     = idx_width(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic [WIDTH-1:0]           rsp_data,
  output logic [IDW-1:0]             rsp_id,
  output logic [WIDTH-1:0]           add_in1,
  output logic [WIDTH-1:0]           add_in2,
  input  logic [WIDTH-1:0]           add_out,
  output logic                       busy
);

  state_t             state, state_nxt;
  logic [IDW-1:0]     rr_ptr, owner, win_idx;
  logic [NUM_REQ-1:0] grant;
  logic               found;
  logic               accept;
  logic [WIDTH-1:0]   op_a, op_b, res, sel_a, sel_b;

  dsp_adder_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .grant_c (grant),
    .index_c (win_idx),
    .found_c (found)
  );

  assign accept = (state == S_IDLE) && found;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (found) state_nxt = S_COMPUTE;
      S_COMPUTE: state_nxt = S_RESPOND;
      S_RESPOND: if (rsp_ready[owner]) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output decode; req_ready is held low while reset is asserted
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    busy      = 1'b0;
    case (state)
      S_IDLE:    if (!rst) req_ready = grant;
      S_COMPUTE: busy = 1'b1;
      S_RESPOND: begin
        busy             = 1'b1;
        rsp_valid[owner] = 1'b1;
      end
      default:   busy = 1'b1;
    endcase
  end

  // Winner's operands
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Operand, owner, pointer and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= IDW'(NUM_REQ - 1);
      owner  <= '0;
      op_a   <= '0;
      op_b   <= '0;
      res    <= '0;
    end else begin
      if (accept) begin
        op_a   <= sel_a;
        op_b   <= sel_b;
        owner  <= win_idx;
        rr_ptr <= win_idx;
      end
      if (state == S_COMPUTE) res <= add_out;
    end
  end

  // Adder inputs come only from registers so request-bus activity never reaches it
  assign add_in1  = op_a;
  assign add_in2  = op_b;
  assign rsp_data = res;
  assign rsp_id   = owner;

endmodule
